// File: rtl/sig_ram_if.sv
// sig_ram_if: bundles the requester and RAM signals of the signal RAM arbiter.
//
// Handshake semantics:
//   cap_valid/cap_ready: a capture sample transfers on every rising clock edge
//     where cap_valid && cap_ready. While cap_valid is high and cap_ready is low,
//     the producer holds cap_chan and cap_sample stable.
//   cpu_req/cpu_ack: the CPU holds cpu_req and its command fields stable until
//     it sees the one-cycle cpu_ack pulse.
//   disp_req: this is a request with no handshake. disp_valid follows two cycles later.
//
// Modports:
//   slave  - the arbiter side (drives responses and the RAM command)
//   master - the requesters/RAM model side
interface sig_ram_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              frame_start;
   logic              disp_req;
   logic              disp_chan;
   logic [9:0]        disp_col;
   logic [11:0]       disp_data;
   logic              disp_valid;
   logic              cap_valid;
   logic              cap_ready;
   logic              cap_chan;
   logic [11:0]       cap_sample;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic [9:0]        ecg_wr_ptr;
   logic [9:0]        emg_wr_ptr;

   modport slave (
      input  frame_start, disp_req, disp_chan, disp_col,
      output disp_data, disp_valid,
      input  cap_valid, cap_chan, cap_sample,
      output cap_ready,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      output ram_addr, ram_wdata, ram_we,
      input  ram_rdata,
      output ecg_wr_ptr, emg_wr_ptr
   );

   modport master (
      output frame_start, disp_req, disp_chan, disp_col,
      input  disp_data, disp_valid,
      output cap_valid, cap_chan, cap_sample,
      input  cap_ready,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      input  ram_addr, ram_wdata, ram_we,
      output ram_rdata,
      input  ecg_wr_ptr, emg_wr_ptr
   );
endinterface

// File: rtl/sig_ram_arbiter.sv
// sig_ram_arbiter: owns the single-port signal RAM that holds the ECG and EMG
// sample windows. It arbitrates one access per cycle between the display reader,
// the capture writer (through a small FIFO) and the CPU port.
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - sig_ram_if.slave, which carries:
//           frame_start                  - pulse that snapshots the write pointers
//           disp_req/chan/col -> disp_data/valid
//                                        - display reads, fixed 2-cycle latency
//           cap_valid/ready/chan/sample  - capture sample stream
//           cpu_req/we/addr/wdata -> cpu_rdata/ack
//                                        - CPU load/store
//           ram_addr/wdata/we, ram_rdata - RAM port with a 1-cycle synchronous read
//           ecg_wr_ptr/emg_wr_ptr        - next write index of each channel
module sig_ram_arbiter #(
   parameter int                ADDR_W       = 12,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] ECG_BASE     = 12'h801,
   parameter logic [ADDR_W-1:0] EMG_BASE     = 12'hC7F,
   parameter int                WIN          = 640,
   parameter int                FIFO_DEPTH   = 4,
   parameter int                CPU_MAX_WAIT = 8
) (
   input logic       clock,
   input logic       reset,
   sig_ram_if.slave  bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [9:0]        WIN_LAST  = 10'(WIN - 1);
   localparam logic [10:0]       WIN_11    = 11'(WIN);
   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(CPU_MAX_WAIT);

   typedef enum logic [2:0] {
      GNT_IDLE,
      GNT_DISP,
      GNT_CPU_URGENT,
      GNT_CAP,
      GNT_CPU
   } grant_t;

   // Capture FIFO entries are {chan, sample}.
   logic [12:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] fifo_wr_idx, fifo_rd_idx;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty, push, pop;

   logic [9:0] ecg_ptr, emg_ptr, snap_ecg, snap_emg;

   logic              cpu_busy, cpu_req_eff, gnt_cpu;
   logic [WAIT_W-1:0] wait_cnt;
   grant_t            grant;

   // Pipeline tags: s1 is the cycle when the RAM sees the address. s2 is the
   // cycle when ram_rdata is valid.
   logic s1_disp, s1_cpu_rd, disp_valid_q, cpu_rd_done_q, cpu_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              ram_we_q;

   logic [9:0]        col_clamped, disp_snap, disp_idx, cap_ptr;
   logic [10:0]       disp_sum;
   logic [ADDR_W-1:0] disp_addr, cap_addr;
   logic              head_chan;
   logic [11:0]       head_sample;

   function automatic logic [9:0] ptr_next(input logic [9:0] p);
      return (p == WIN_LAST) ? 10'd0 : p + 10'd1;
   endfunction

   assign fifo_full  = (fifo_count == FIFO_FULL);
   assign fifo_empty = (fifo_count == '0);
   assign push       = bus.cap_valid && !fifo_full;
   assign pop        = (grant == GNT_CAP);

   assign head_chan   = fifo_mem[fifo_rd_idx][12];
   assign head_sample = fifo_mem[fifo_rd_idx][11:0];
   assign cap_ptr     = head_chan ? emg_ptr : ecg_ptr;
   assign cap_addr    = (head_chan ? EMG_BASE : ECG_BASE) + ADDR_W'(cap_ptr);

   // Both addends are below WIN, so one conditional subtract gives the modulo.
   assign col_clamped = (bus.disp_col > WIN_LAST) ? WIN_LAST : bus.disp_col;
   assign disp_snap   = bus.disp_chan ? snap_emg : snap_ecg;
   assign disp_sum    = {1'b0, disp_snap} + {1'b0, col_clamped};
   assign disp_idx    = (disp_sum >= WIN_11) ? 10'(disp_sum - WIN_11) : disp_sum[9:0];
   assign disp_addr   = (bus.disp_chan ? EMG_BASE : ECG_BASE) + ADDR_W'(disp_idx);

   // An accepted CPU request is invisible until its ack, so it is never reissued.
   // The request also does not age the wait counter during that time.
   assign cpu_req_eff = bus.cpu_req && !cpu_busy;

   always_comb begin
      grant = GNT_IDLE;
      if (bus.disp_req)                                grant = GNT_DISP;
      else if (cpu_req_eff && (wait_cnt >= WAIT_MAX))  grant = GNT_CPU_URGENT;
      else if (!fifo_empty)                            grant = GNT_CAP;
      else if (cpu_req_eff)                            grant = GNT_CPU;
   end

   assign gnt_cpu = (grant == GNT_CPU_URGENT) || (grant == GNT_CPU);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         fifo_wr_idx   <= '0;
         fifo_rd_idx   <= '0;
         fifo_count    <= '0;
         ecg_ptr       <= '0;
         emg_ptr       <= '0;
         snap_ecg      <= '0;
         snap_emg      <= '0;
         cpu_busy      <= 1'b0;
         wait_cnt      <= '0;
         s1_disp       <= 1'b0;
         s1_cpu_rd     <= 1'b0;
         disp_valid_q  <= 1'b0;
         cpu_rd_done_q <= 1'b0;
         cpu_ack_q     <= 1'b0;
         cpu_rdata_q   <= '0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[fifo_wr_idx] <= {bus.cap_chan, bus.cap_sample};
            fifo_wr_idx           <= fifo_wr_idx + 1'b1;
         end
         if (pop) fifo_rd_idx <= fifo_rd_idx + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         if (pop) begin
            if (head_chan) emg_ptr <= ptr_next(emg_ptr);
            else           ecg_ptr <= ptr_next(ecg_ptr);
         end

         // The registered pointers still hold their pre-increment values, so
         // a capture write in this same cycle does not leak into the snapshot.
         if (bus.frame_start) begin
            snap_ecg <= ecg_ptr;
            snap_emg <= emg_ptr;
         end

         ram_we_q <= 1'b0;
         case (grant)
            GNT_DISP: ram_addr_q <= disp_addr;
            GNT_CAP: begin
               ram_addr_q  <= cap_addr;
               ram_wdata_q <= DATA_W'(head_sample);
               ram_we_q    <= 1'b1;
            end
            GNT_CPU, GNT_CPU_URGENT: begin
               ram_addr_q <= bus.cpu_addr;
               if (bus.cpu_we) begin
                  ram_wdata_q <= bus.cpu_wdata;
                  ram_we_q    <= 1'b1;
               end
            end
            default: ram_addr_q <= ram_addr_q;
         endcase

         s1_disp       <= (grant == GNT_DISP);
         s1_cpu_rd     <= gnt_cpu && !bus.cpu_we;
         disp_valid_q  <= s1_disp;
         cpu_rd_done_q <= s1_cpu_rd;
         cpu_ack_q     <= (gnt_cpu && bus.cpu_we) || s1_cpu_rd;
         if (cpu_rd_done_q) cpu_rdata_q <= bus.ram_rdata;

         if (gnt_cpu)        cpu_busy <= 1'b1;
         else if (cpu_ack_q) cpu_busy <= 1'b0;

         if (!cpu_req_eff || gnt_cpu)  wait_cnt <= '0;
         else if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign bus.cap_ready  = !fifo_full;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.disp_valid = disp_valid_q;
   // Read data arrives from the RAM in the s2 cycle and is passed straight through.
   assign bus.disp_data  = disp_valid_q ? bus.ram_rdata[11:0] : 12'd0;
   assign bus.cpu_rdata  = cpu_rd_done_q ? bus.ram_rdata : cpu_rdata_q;
   assign bus.cpu_ack    = cpu_ack_q;
   assign bus.ecg_wr_ptr = ecg_ptr;
   assign bus.emg_wr_ptr = emg_ptr;
endmodule

// File: tb/tb_sig_ram_arbiter.sv
module tb_sig_ram_arbiter;
   localparam logic [11:0] ECG_BASE = 12'h801;
   localparam logic [11:0] EMG_BASE = 12'hC7F;

   logic clock;
   logic reset;
   logic ram_clear;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   gnt_k;
   logic [31:0] mem [4096];
   logic [43:0] exp_q [$];   // expected {ram_addr, ram_wdata} of capture writes
   logic [43:0] exp_w;

   sig_ram_if bus ();

   sig_ram_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // RAM model: single port, read-before-write, 1-cycle synchronous read.
   always @(posedge clock) begin
      if (ram_clear) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
         bus.ram_rdata <= '0;
      end else begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Offers a sample and returns after the edge where it was accepted.
   // cap_valid is left high.
   task automatic cap_push(input logic chan, input logic [11:0] sample);
      int guard;
      guard = 0;
      bus.cap_valid  = 1'b1;
      bus.cap_chan   = chan;
      bus.cap_sample = sample;
      while (!bus.cap_ready && guard < 20) begin
         step();
         guard++;
      end
      if (!bus.cap_ready) check("cap_ready_wait", 32'(bus.cap_ready), 32'd1);
      step();
   endtask

   // ---------------- stimulus + scoreboard ----------------
   initial begin
      reset           = 1'b0;
      ram_clear       = 1'b1;
      bus.frame_start = 1'b0;
      bus.disp_req    = 1'b0;
      bus.disp_chan   = 1'b0;
      bus.disp_col    = '0;
      bus.cap_valid   = 1'b0;
      bus.cap_chan    = 1'b0;
      bus.cap_sample  = '0;
      bus.cpu_req     = 1'b0;
      bus.cpu_we      = 1'b0;
      bus.cpu_addr    = '0;
      bus.cpu_wdata   = '0;
      step();
      step();

      // 1. Reset state
      check("rst_cap_ready", 32'(bus.cap_ready), 32'd1);
      check("rst_ecg_ptr", 32'(bus.ecg_wr_ptr), 32'd0);
      check("rst_emg_ptr", 32'(bus.emg_wr_ptr), 32'd0);
      check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
      check("rst_ram_we", 32'(bus.ram_we), 32'd0);
      check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
      reset     = 1'b1;
      ram_clear = 1'b0;
      step();

      // 1b. Reset asserted in the middle of a CPU read
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 12'h123;
      step();
      check("midrd_ram_addr", 32'(bus.ram_addr), 32'h123);
      #1 reset = 1'b0;
      #1;
      check("midrd_rst_addr", 32'(bus.ram_addr), 32'h0);
      check("midrd_rst_ack", 32'(bus.cpu_ack), 32'd0);
      bus.cpu_req = 1'b0;
      step();
      check("midrd_no_ack1", 32'(bus.cpu_ack), 32'd0);
      step();
      check("midrd_no_ack2", 32'(bus.cpu_ack), 32'd0);
      reset = 1'b1;
      step();

      // 2. ECG capture of 642 samples, wraps the pointer to 2
      for (int i = 0; i < 642; i++) cap_push(1'b0, 12'(i));
      bus.cap_valid = 1'b0;
      repeat (4) step();
      check("cap_ecg_ptr_wrap", 32'(bus.ecg_wr_ptr), 32'd2);
      check("cap_mem0", mem[ECG_BASE], 32'd640);
      check("cap_mem1", mem[ECG_BASE + 12'd1], 32'd641);
      check("cap_mem2", mem[ECG_BASE + 12'd2], 32'd2);

      // 3. Display reads with snapshot ECG=5, EMG=0
      cap_push(1'b0, 12'd100);
      cap_push(1'b0, 12'd101);
      cap_push(1'b0, 12'd102);
      bus.cap_valid = 1'b0;
      repeat (4) step();
      check("disp_pre_ecg_ptr", 32'(bus.ecg_wr_ptr), 32'd5);
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      bus.disp_req  = 1'b1;
      bus.disp_chan = 1'b0;
      bus.disp_col  = 10'd0;
      step();
      check("disp_col0_addr", 32'(bus.ram_addr), 32'h806);
      check("disp_col0_we", 32'(bus.ram_we), 32'd0);
      check("disp_col0_valid_early", 32'(bus.disp_valid), 32'd0);
      bus.disp_col = 10'd639;
      step();
      check("disp_col0_valid", 32'(bus.disp_valid), 32'd1);
      check("disp_col0_data", 32'(bus.disp_data), 32'd5);
      check("disp_col639_addr", 32'(bus.ram_addr), 32'h805);
      bus.disp_chan = 1'b1;
      bus.disp_col  = 10'd10;
      step();
      check("disp_col639_data", 32'(bus.disp_data), 32'd102);
      check("disp_emg10_addr", 32'(bus.ram_addr), 32'hC89);
      bus.disp_chan = 1'b0;
      bus.disp_col  = 10'd700;
      step();
      check("disp_emg10_data", 32'(bus.disp_data), 32'd0);
      check("disp_clamp_addr", 32'(bus.ram_addr), 32'h805);
      bus.disp_req = 1'b0;
      step();
      check("disp_clamp_data", 32'(bus.disp_data), 32'd102);
      check("disp_clamp_valid", 32'(bus.disp_valid), 32'd1);
      step();
      check("disp_valid_drop", 32'(bus.disp_valid), 32'd0);

      // 4. Display held, FIFO fills, capture resumes when display releases
      bus.disp_req  = 1'b1;
      bus.disp_chan = 1'b0;
      bus.disp_col  = 10'd0;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         cap_push(1'b1, 12'h0A0 + 12'(i));
         exp_q.push_back({EMG_BASE + 12'(i), 32'h0A0 + 32'(i)});
      end
      check("full_cap_ready", 32'(bus.cap_ready), 32'd0);
      bus.cap_sample = 12'h0A4;
      for (int i = 0; i < 3; i++) begin
         check("full_no_write", 32'(bus.ram_we), 32'd0);
         check("full_disp_valid", 32'(bus.disp_valid), 32'd1);
         check("full_disp_data", 32'(bus.disp_data), 32'd5);
         step();
      end
      bus.cap_valid = 1'b0;
      bus.disp_req  = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         check("drain_we", 32'(bus.ram_we), 32'd1);
         exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 44'h0;
         check("drain_addr", 32'(bus.ram_addr), 32'(exp_w[43:32]));
         check("drain_wdata", bus.ram_wdata, exp_w[31:0]);
         step();
      end
      check("drain_done_we", 32'(bus.ram_we), 32'd0);
      check("drain_cap_ready", 32'(bus.cap_ready), 32'd1);
      check("drain_emg_ptr", 32'(bus.emg_wr_ptr), 32'd4);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      // 6. frame_start coincident with an ECG write at ptr 7
      cap_push(1'b0, 12'h055);
      cap_push(1'b0, 12'h066);
      bus.cap_valid = 1'b0;
      repeat (4) step();
      check("snap_pre_ptr", 32'(bus.ecg_wr_ptr), 32'd7);
      cap_push(1'b0, 12'h077);
      bus.cap_valid   = 1'b0;
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      check("snap_ecg_ptr", 32'(bus.ecg_wr_ptr), 32'd8);
      check("snap_write_addr", 32'(bus.ram_addr), 32'h808);
      step();
      bus.disp_req  = 1'b1;
      bus.disp_chan = 1'b0;
      bus.disp_col  = 10'd0;
      step();
      check("snap_disp_addr", 32'(bus.ram_addr), 32'h808);
      bus.disp_req = 1'b0;
      step();
      check("snap_disp_data", 32'(bus.disp_data), 32'h077);

      // CPU write then read back, with the RAM otherwise idle
      step();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 12'h010;
      bus.cpu_wdata = 32'hDEADBEEF;
      step();
      check("cpuwr_we", 32'(bus.ram_we), 32'd1);
      check("cpuwr_addr", 32'(bus.ram_addr), 32'h010);
      check("cpuwr_wdata", bus.ram_wdata, 32'hDEADBEEF);
      check("cpuwr_ack", 32'(bus.cpu_ack), 32'd1);
      bus.cpu_req = 1'b0;
      step();
      check("cpuwr_ack_pulse", 32'(bus.cpu_ack), 32'd0);
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b0;
      step();
      check("cpurd_ack_early", 32'(bus.cpu_ack), 32'd0);
      step();
      check("cpurd_ack", 32'(bus.cpu_ack), 32'd1);
      check("cpurd_data", bus.cpu_rdata, 32'hDEADBEEF);
      bus.cpu_req = 1'b0;
      step();
      check("cpurd_single_ack", 32'(bus.cpu_ack), 32'd0);

      // 5. Continuous capture stream with a CPU read held: override at wait 8
      bus.cap_valid  = 1'b1;
      bus.cap_chan   = 1'b0;
      bus.cap_sample = 12'h300;
      step();
      bus.cap_sample = 12'h301;
      step();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 12'h802;
      gnt_k = -1;
      for (int k = 0; k < 20 && gnt_k < 0; k++) begin
         bus.cap_sample = 12'h302 + 12'(k);
         step();
         if (!bus.ram_we) gnt_k = k;
      end
      check("cpu_grant_cycle", 32'(gnt_k), 32'd8);
      check("cpu_grant_addr", 32'(bus.ram_addr), 32'h802);
      check("cpu_stream_ack_early", 32'(bus.cpu_ack), 32'd0);
      step();
      check("cpu_stream_ack", 32'(bus.cpu_ack), 32'd1);
      check("cpu_stream_rdata", bus.cpu_rdata, 32'd641);
      bus.cap_valid = 1'b0;
      bus.cpu_req   = 1'b0;
      step();
      check("cpu_stream_ack_drop", 32'(bus.cpu_ack), 32'd0);
      check("cpu_rdata_hold", bus.cpu_rdata, 32'd641);
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sig_ram_arbiter.md
Name: sig_ram_arbiter

Overview:
- Owns the single-port synchronous signal RAM that holds the ECG and EMG sample windows.
- Arbitrates access between three requesters: the VGA display reader, the ADC capture writer and the CPU load/store port.
- Maintains one circular write pointer per channel.
- Translates display column requests into oldest-first RAM addresses, using a pointer snapshot latched once per frame.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 32, RAM data width
ECG_BASE, 12'h801, first word of the ECG window
EMG_BASE, 12'hC7F, first word of the EMG window
WIN, 640, samples per channel window (one per screen column)
FIFO_DEPTH, 4, capture write buffer depth (power of 2)
CPU_MAX_WAIT, 8, cycles a pending CPU request waits before it overrides capture

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at end of frame (from VGA timing screenEnd, already synchronous to clock)
disp_req  in  1  display read request, may be held every cycle
disp_chan  in  1  0=ECG, 1=EMG
disp_col  in  10  screen column 0..WIN-1
disp_data  out  12  sample returned to display
disp_valid  out  1  disp_data valid
cap_valid  in  1  capture sample offered
cap_ready  out  1  capture sample accepted when cap_valid&&cap_ready
cap_chan  in  1  0=ECG, 1=EMG
cap_sample  in  12  ADC sample
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data
cpu_ack  out  1  one-cycle completion pulse
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read
ecg_wr_ptr  out  10  next ECG write index
emg_wr_ptr  out  10  next EMG write index

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs, pointers, snapshots, the wait counter and the FIFO are cleared.
  - cap_ready=1, since it is combinational !full.
  - Any in-flight access is dropped and no cpu_ack is issued for it.
- Grant (evaluated every cycle at cycle T; one grant per cycle):
  - Priority 1: display, whenever disp_req=1.
  - Priority 2: CPU, if cpu_req=1 and wait_cnt>=CPU_MAX_WAIT.
  - Priority 3: capture, if the FIFO is not empty.
  - Priority 4: CPU, if cpu_req=1.
  - Otherwise idle.
  - Display is never delayed.
- Registered outputs: ram_addr, ram_wdata and ram_we are registered at the end of T and present during T+1. ram_we=0 on all non-write cycles.
- Display path:
  - Address = base + ((snap_ptr[chan] + disp_col) mod WIN).
  - The mod is one conditional subtract, because both operands are < WIN.
  - disp_data = ram_rdata[11:0] and disp_valid=1 at T+2. Fixed latency 2 cycles.
  - disp_col >= WIN: the column is clamped to WIN-1.
- Capture path:
  - A handshake pushes {chan, sample} into the FIFO. cap_ready = !full.
  - A pop is written as ram_wdata = {20'b0, sample} to base + wr_ptr[chan].
  - wr_ptr[chan] increments on the grant cycle and wraps from WIN-1 to 0.
  - A push and a pop in the same cycle are allowed when the FIFO is non-full. The count is then unchanged.
- CPU path:
  - Write: cpu_ack at T+1.
  - Read: cpu_rdata = ram_rdata and cpu_ack at T+2.
  - After grant, the arbiter ignores cpu_req until the ack has been issued, so there is no double-issue.
  - cpu_rdata holds its value until the next CPU read completes.
- Wait counter:
  - wait_cnt increments each cycle that cpu_req=1 and the CPU is not granted. It saturates at CPU_MAX_WAIT.
  - It clears on CPU grant or when cpu_req=0.
- Snapshot:
  - On frame_start, snap_ptr[c] <= wr_ptr[c] for both channels.
  - If a capture write happens in the same cycle, the snapshot takes the pre-increment value.
  - Result: column 0 shows the oldest sample of the frame.
- No address protection: CPU writes into the sample windows are allowed and are not blocked.

Test Plan:
1. Reset → cap_ready=1, ptrs=0, disp_valid=0, ram_we=0. Assert reset mid-CPU-read → no cpu_ack, all outputs cleared asynchronously.
2. ECG capture of 642 samples (value=index) with disp_req=0 → ecg_wr_ptr wraps and ends at 2. RAM[ECG_BASE+0]=640, RAM[ECG_BASE+1]=641, RAM[ECG_BASE+2]=2.
3. Display read, frame_start with ecg_wr_ptr=5:
   - disp_chan=0, disp_col=0 → ram_addr=12'h806 at T+1, disp_valid at T+2.
   - disp_col=639 → ram_addr=12'h805.
   - EMG, snap_ptr 0, col 10 → 12'hC89.
4. disp_req held high with a full FIFO → cap_ready=0, no capture writes, and display is uninterrupted. Release disp_req → 4 consecutive capture writes, then cap_ready=1.
5. disp_req low, capture stream continuous, cpu_req read held → CPU granted no later than the 9th cycle. cpu_ack arrives 2 cycles after grant with the correct cpu_rdata.
6. frame_start coincident with an ECG write at ptr=7 → snap_ptr=7 and ecg_wr_ptr=8.
